ahb_cmd_master: RTL and testbench

AHB_CMD_MASTER -- requirements
Module: ahb_cmd_master

---
 rtl/ahb_cmd_master_pkg.sv | 28 ++
 rtl/ahb_cmd_master.sv | 167 ++++++++++++++++
 tb/tb_ahb_cmd_master.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_cmd_master_pkg.sv
// Shared constants for the AHB-Lite command master: HTRANS codes, fixed
// HSIZE/HBURST/HPROT values and the controller state encoding.
// Macro AHB_CMD_MASTER_ERR_ABORT_EN selects abort-on-ERROR behaviour.
package ahb_cmd_master_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

  // RUN: address phases still to issue; DRAIN: only the last data phase left;
  // ERR: second cycle of a two-cycle ERROR response (abort build only).
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_ERR   = 2'd3
  } state_t;

`ifdef AHB_CMD_MASTER_ERR_ABORT_EN
  localparam bit ERR_ABORT = 1'b1;
`else
  localparam bit ERR_ABORT = 1'b0;
`endif

endpackage

// File: rtl/ahb_cmd_master.sv
// AHB-Lite initiator executing one command of cmd_len+1 word transfers
// (SINGLE/NONSEQ, pipelined address/data) from a valid/ready command port.
// Ports: cmd_* command in; wr_* write stream in; rd_* read stream out (no
// backpressure); done/err/busy status; H* AHB-Lite initiator signals.
// Macro AHB_CMD_MASTER_ERR_ABORT_EN: abort the command on the first ERROR
// cycle; otherwise finish all transfers and report a sticky error with done.
module ahb_cmd_master
  import ahb_cmd_master_pkg::*;
#(
  parameter int AWIDTH = 32,
  parameter int LEN_W  = 8
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  // command port
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [AWIDTH-1:0] cmd_addr,
  input  logic              cmd_write,
  input  logic [LEN_W-1:0]  cmd_len,
  // write-data stream
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [31:0]       wr_data,
  // read-data stream
  output logic              rd_valid,
  output logic [31:0]       rd_data,
  // status
  output logic              done,
  output logic              err,
  output logic              busy,
  // AHB-Lite initiator
  output logic [AWIDTH-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic [3:0]        HPROT,
  output logic [31:0]       HWDATA,
  input  logic [31:0]       HRDATA,
  input  logic              HREADY,
  input  logic              HRESP
);

  state_t state, state_nxt;

  logic [AWIDTH-1:0] haddr_q;
  logic              hwrite_q;
  logic [31:0]       hwdata_q;
  logic [LEN_W-1:0]  cnt_q;     // address phases left to issue, minus one
  logic              dp_pend;   // a data phase is outstanding on the bus
  logic              err_q;     // sticky error for the current command

  logic cmd_acc;
  logic addr_acc;
  logic dp_done;
  logic err_first;
  logic abort_now;

  // Word accesses only: the low address bits are dropped at acceptance.
  logic addr_lsb_unused;
  assign addr_lsb_unused = ^cmd_addr[1:0];

  assign cmd_acc   = cmd_valid && cmd_ready;
  assign addr_acc  = (HTRANS == HTRANS_NONSEQ) && HREADY;
  // First cycle of the two-cycle ERROR response for the outstanding transfer.
  assign err_first = dp_pend && HRESP && !HREADY;
  assign abort_now = ERR_ABORT && err_first;
  assign dp_done   = dp_pend && HREADY && ((state == ST_RUN) || (state == ST_DRAIN));

  assign HADDR   = haddr_q;
  assign HWRITE  = hwrite_q;
  assign HWDATA  = hwdata_q;
  assign HSIZE   = HSIZE_WORD;
  assign HBURST  = HBURST_SINGLE;
  assign HPROT   = HPROT_DEFAULT;
  assign rd_data = HRDATA;

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (cmd_valid) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (abort_now)                          state_nxt = ST_ERR;
        else if (addr_acc && (cnt_q == '0))     state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (abort_now)   state_nxt = ST_ERR;
        else if (HREADY) state_nxt = ST_IDLE;
      end
      ST_ERR: begin
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // ------------------------------------------------------------------ outputs
  always_comb begin
    cmd_ready = (state == ST_IDLE);
    busy      = (state != ST_IDLE);
    HTRANS    = HTRANS_IDLE;
    done      = 1'b0;
    err       = 1'b0;
    // Writes only issue when a data word is on offer; the stream keeps
    // wr_valid high until wr_ready, so a stalled NONSEQ stays presented.
    if ((state == ST_RUN) && (!hwrite_q || wr_valid) && !abort_now) begin
      HTRANS = HTRANS_NONSEQ;
    end
    case (state)
      ST_DRAIN: begin
        done = HREADY;
        err  = HREADY && (err_q || HRESP);
      end
      ST_ERR: begin
        done = 1'b1;
        err  = 1'b1;
      end
      default: ;
    endcase
    wr_ready = addr_acc && hwrite_q;
    rd_valid = dp_done && !hwrite_q && !HRESP;
  end

  // ----------------------------------------------------------------- datapath
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      haddr_q  <= '0;
      hwrite_q <= 1'b0;
      hwdata_q <= '0;
      cnt_q    <= '0;
      dp_pend  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (cmd_acc) begin
        haddr_q  <= {cmd_addr[AWIDTH-1:2], 2'b00};
        hwrite_q <= cmd_write;
        cnt_q    <= cmd_len;
      end else if (addr_acc) begin
        haddr_q  <= haddr_q + AWIDTH'(4);
        cnt_q    <= cnt_q - LEN_W'(1);
      end

      // Write data moves into its data phase together with the address.
      if (wr_ready) hwdata_q <= wr_data;

      if (addr_acc)                  dp_pend <= 1'b1;
      else if (HREADY || abort_now)  dp_pend <= 1'b0;

      if (cmd_acc)                   err_q <= 1'b0;
      else if (dp_pend && HRESP)     err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ahb_cmd_master.sv
module tb_ahb_cmd_master;

`ifdef AHB_CMD_MASTER_ERR_ABORT_EN
  localparam bit ABORT = 1'b1;
`else
  localparam bit ABORT = 1'b0;
`endif

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        cmd_valid, cmd_write, cmd_ready;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic        wr_valid, wr_ready;
  logic [31:0] wr_data;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        done, err, busy;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE, HREADY, HRESP;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;

  ahb_cmd_master #(.AWIDTH(32), .LEN_W(8)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_write(cmd_write), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .done(done), .err(err), .busy(busy),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HPROT(HPROT), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .HREADY(HREADY), .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // memory behind the slave model
  logic [31:0] mem [logic [31:0]];
  // expected address stream / offered write words / per-transfer knobs
  logic [31:0] exp_addr_q[$];
  logic [31:0] wr_src_q[$];
  int          wait_tbl[$];
  int          gap_tbl[$];
  int          gap_cnt = 0;
  int          err_idx = -1;
  int          xfer_idx = 0;
  bit          exp_write = 0;
  bit          exp_busy = 0;
  // slave data-phase state
  bit          dp_act = 0, dp_wr = 0, dp_err = 0;
  logic [31:0] dp_addr, dp_wdat;
  int          dp_wait = 0, err_ph = 0;
  // observations
  int          n_rd = 0, n_done = 0;
  bit          acc_seen = 0, done_err = 0;
  int          acc_cyc = 0, done_cyc = 0, first_addr_cyc = 0, last_addr_cyc = 0, err1_cyc = 0;
  // previous-cycle bus snapshot
  bit          prev_valid = 0, prev_hready = 1, prev_done = 0, prev_hwrite = 0;
  logic [1:0]  prev_htrans;
  logic [31:0] prev_haddr, prev_hwdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic chk_reset(input string p);
    chk({p, "_htrans"}, 32'(HTRANS), 32'h0);
    chk({p, "_haddr"},  HADDR, 32'h0);
    chk({p, "_hwrite"}, 32'(HWRITE), 32'h0);
    chk({p, "_hwdata"}, HWDATA, 32'h0);
    chk({p, "_rdv"},    32'(rd_valid), 32'h0);
    chk({p, "_done"},   32'(done), 32'h0);
    chk({p, "_err"},    32'(err), 32'h0);
    chk({p, "_busy"},   32'(busy), 32'h0);
    chk({p, "_wrrdy"},  32'(wr_ready), 32'h0);
  endtask

  // One bus cycle: drive slave/stream at negedge, check, advance the model.
  task automatic cycle();
    bit acc;
    @(negedge HCLK);
    wr_valid = (wr_src_q.size() > 0) && (gap_cnt == 0);
    wr_data  = wr_valid ? wr_src_q[0] : 32'h0;
    HRESP = 1'b0; HREADY = 1'b1; HRDATA = 32'hDEAD_BEEF;
    if (dp_act) begin
      if (dp_err) begin HRESP = 1'b1; HREADY = (err_ph == 1); end
      else HREADY = (dp_wait == 0);
      if (!dp_wr) HRDATA = mem_rd(dp_addr);
    end
    #1;
    chk("busy", 32'(busy), 32'(exp_busy));
    chk("cmd_ready", 32'(cmd_ready), 32'(!exp_busy));
    chk("hsize_hburst_hprot", {22'h0, HSIZE, HBURST, HPROT}, {22'h0, 3'b010, 3'b000, 4'b0011});
    if (prev_valid && !prev_hready) begin
      chk("hold_haddr", HADDR, prev_haddr);
      chk("hold_hwdata", HWDATA, prev_hwdata);
      if (prev_htrans == 2'b10 && !(ABORT && HRESP)) begin
        chk("hold_htrans", 32'(HTRANS), 32'h2);
        chk("hold_hwrite", 32'(HWRITE), 32'(prev_hwrite));
      end
    end
    if (prev_done) chk("ready_after_done", 32'(cmd_ready), 32'h1);
    if (exp_write && exp_busy && !wr_valid) chk("gap_idle", 32'(HTRANS), 32'h0);
    if (dp_act && dp_err && err_ph == 0) begin
      err1_cyc = cyc;
      if (ABORT) chk("abort_idle", 32'(HTRANS), 32'h0);
    end
    // data phase completion
    if (dp_act && HREADY) begin
      if (dp_wr) begin
        chk("rd_valid_wr", 32'(rd_valid), 32'h0);
        if (!dp_err) begin
          chk("hwdata", HWDATA, dp_wdat);
          mem[dp_addr] = dp_wdat;
        end
      end else if (dp_err) begin
        chk("rd_valid_err", 32'(rd_valid), 32'h0);
      end else begin
        chk("rd_valid", 32'(rd_valid), 32'h1);
        chk("rd_data", rd_data, mem_rd(dp_addr));
        n_rd++;
      end
    end else begin
      chk("rd_valid_idle", 32'(rd_valid), 32'h0);
    end
    // address phase
    acc = (HTRANS == 2'b10) && HREADY;
    if (acc) begin
      if (exp_addr_q.size() == 0) chk("extra_addr", 32'(HTRANS), 32'h0);
      else begin
        chk("haddr", HADDR, exp_addr_q.pop_front());
        chk("hwrite", 32'(HWRITE), 32'(exp_write));
      end
      chk("wr_ready", 32'(wr_ready), 32'(exp_write));
      if (xfer_idx == 0) first_addr_cyc = cyc;
      last_addr_cyc = cyc;
    end else begin
      chk("wr_ready_idle", 32'(wr_ready), 32'h0);
    end
    if (cmd_valid && cmd_ready) begin acc_seen = 1; acc_cyc = cyc; end
    if (done) begin n_done++; done_err = err; done_cyc = cyc; end
    // advance slave
    if (dp_act) begin
      if (HREADY) dp_act = 0;
      else if (dp_err) err_ph = 1;
      else dp_wait--;
    end
    if (acc) begin
      dp_act = 1; dp_addr = HADDR; dp_wr = HWRITE; dp_wdat = wr_data;
      dp_wait = (wait_tbl.size() > 0) ? wait_tbl.pop_front() : 0;
      dp_err = (xfer_idx == err_idx); err_ph = 0;
      xfer_idx++;
    end
    // advance write stream
    if (wr_ready && wr_valid) begin
      void'(wr_src_q.pop_front());
      gap_cnt = (gap_tbl.size() > 0) ? gap_tbl.pop_front() : 0;
    end else if (gap_cnt > 0) gap_cnt--;
    if (cmd_valid && cmd_ready) exp_busy = 1;
    if (done) exp_busy = 0;
    prev_valid = 1; prev_hready = HREADY; prev_htrans = HTRANS; prev_haddr = HADDR;
    prev_hwdata = HWDATA; prev_hwrite = HWRITE; prev_done = done;
    cyc++;
    @(posedge HCLK); #1;
  endtask

  task automatic start_cmd(input bit wr, input logic [31:0] addr, input int len, input int err_at);
    logic [31:0] base;
    int k;
    exp_write = wr; err_idx = err_at; xfer_idx = 0; n_rd = 0; n_done = 0; acc_seen = 0;
    exp_addr_q.delete();
    base = addr & 32'hFFFF_FFFC;
    for (int i = 0; i <= len; i++) exp_addr_q.push_back(base + 32'(i) * 32'd4);
    if (wr) for (int i = 0; i <= len; i++) wr_src_q.push_back($urandom);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = 8'(len);
    k = 0;
    while (!acc_seen && k < 20) begin cycle(); k++; end
    chk("cmd_accept", 32'(acc_seen), 32'h1);
    cmd_valid = 1'b0;
  endtask

  task automatic finish_cmd(input int len, input int err_at);
    int k;
    bit exp_err;
    int exp_rd, exp_left;
    k = 0;
    while (n_done == 0 && k < 300) begin cycle(); k++; end
    chk("done_seen", 32'(n_done), 32'h1);
    cycle(); cycle();
    chk("done_once", 32'(n_done), 32'h1);
    exp_err  = (err_at >= 0) && (err_at <= len);
    exp_rd   = exp_write ? 0 : (exp_err ? (ABORT ? err_at : len) : len + 1);
    exp_left = (exp_err && ABORT) ? len - err_at : 0;
    chk("done_err", 32'(done_err), 32'(exp_err));
    chk("rd_count", 32'(n_rd), 32'(exp_rd));
    chk("addr_left", 32'(exp_addr_q.size()), 32'(exp_left));
    wr_src_q.delete(); gap_tbl.delete(); wait_tbl.delete(); exp_addr_q.delete();
    gap_cnt = 0; err_idx = -1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, eat;
    HRESETn = 1'b0; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0;
    wr_valid = 0; wr_data = 0; HRDATA = 0; HREADY = 1; HRESP = 0;
    #1;
    chk_reset("rst");
    repeat (2) @(posedge HCLK);
    @(negedge HCLK) HRESETn = 1'b1;
    @(posedge HCLK); #1;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'h1);

    // zero-wait read of 4 words: addresses in cycles 1..4, done in cycle 5
    start_cmd(0, 32'h0000_1000, 3, -1);
    finish_cmd(3, -1);
    chk("zw_first_addr", 32'(first_addr_cyc), 32'(acc_cyc + 1));
    chk("zw_last_addr",  32'(last_addr_cyc),  32'(acc_cyc + 4));
    chk("zw_done",       32'(done_cyc),       32'(acc_cyc + 5));

    // write of 2 words, stream stalls 2 cycles before the second word
    gap_tbl.push_back(2);
    start_cmd(1, 32'h0000_2000, 1, -1);
    finish_cmd(1, -1);

    // read back what was written, 3 wait states on the first data phase
    wait_tbl.push_back(3); wait_tbl.push_back(0);
    start_cmd(0, 32'h0000_2000, 1, -1);
    finish_cmd(1, -1);

    // ERROR on the second of four reads
    start_cmd(0, 32'h0000_4000, 3, 1);
    finish_cmd(3, 1);
    chk("err_done_cyc", 32'(done_cyc), 32'(err1_cyc + (ABORT ? 1 : 3)));

    // address wrap at the top of the space
    start_cmd(0, 32'hFFFF_FFFC, 1, -1);
    finish_cmd(1, -1);

    // reset in the middle of a write
    for (int i = 0; i < 4; i++) wait_tbl.push_back(1);
    start_cmd(1, 32'h0000_5000, 3, -1);
    repeat (3) cycle();
    HRESETn = 1'b0; #1;
    chk_reset("rst_mid");
    chk("rst_mid_nodone", 32'(n_done), 32'h0);
    repeat (2) @(posedge HCLK);
    @(negedge HCLK) HRESETn = 1'b1;
    HREADY = 1; HRESP = 0; wr_valid = 0;
    dp_act = 0; prev_valid = 0; prev_done = 0; exp_busy = 0;
    wr_src_q.delete(); gap_tbl.delete(); wait_tbl.delete(); exp_addr_q.delete(); gap_cnt = 0;
    @(posedge HCLK); #1;
    start_cmd(0, 32'h0000_3001, 1, -1);
    finish_cmd(1, -1);

    // randomized commands
    for (int n = 0; n < 40; n++) begin
      len = $urandom_range(0, 5);
      eat = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len) : -1;
      for (int i = 0; i <= len; i++) begin
        wait_tbl.push_back($urandom_range(0, 2));
        gap_tbl.push_back($urandom_range(0, 2));
      end
      start_cmd(1'($urandom_range(0, 1)), {16'h0000, 4'(n % 3), 12'($urandom)}, len, eat);
      finish_cmd(len, eat);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
